// File: rtl/sram_512x80_ctrl_if.sv
// rtl/sram_512x80_ctrl_if.sv - request/response word bus between crossbar port and SRAM controller
interface sram_512x80_ctrl_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [8:0]  addr_i;
  logic [79:0] wdata_i;
  logic [79:0] wmask_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [79:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, wmask_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, wmask_i, rready_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sram_512x80_ctrl.sv
// rtl/sram_512x80_ctrl.sv - initiator-side controller for the 512x80 bit-enable SRAM macro
module sram_512x80_ctrl #(
  parameter bit         INIT_ON_RESET = 1'b1,
  parameter logic [2:0] MC_VAL        = 3'b000,
  parameter logic       MCEN_VAL      = 1'b0,
  parameter logic [1:0] WA_VAL        = 2'b00,
  parameter logic [1:0] WPULSE_VAL    = 2'b00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sram_512x80_ctrl_if.slave    bus,
  input  logic                 init_req_i,
  output logic                 init_done_o,
  output logic                 sram_ren_o,
  output logic                 sram_wen_o,
  output logic [8:0]           sram_adr_o,
  output logic [79:0]          sram_din_o,
  output logic [79:0]          sram_wbeb_o,
  output logic [2:0]           sram_mc_o,
  output logic                 sram_mcen_o,
  output logic                 sram_clkbyp_o,
  output logic [1:0]           sram_wa_o,
  output logic [1:0]           sram_wpulse_o,
  output logic                 sram_wpulseen_o,
  output logic                 sram_fwen_o,
  input  logic [79:0]          sram_q_i
);

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;
  logic [79:0] fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  fcnt_q;

  logic        rvalid, push, pop, gnt, read_ok;
  logic [1:0]  occ, occ_after;

  assign sram_mc_o       = MC_VAL;
  assign sram_mcen_o     = MCEN_VAL;
  assign sram_clkbyp_o   = 1'b0;
  assign sram_wa_o       = WA_VAL;
  assign sram_wpulse_o   = WPULSE_VAL;
  assign sram_wpulseen_o = 1'b0;
  assign sram_fwen_o     = 1'b0;

  // A read issued last cycle lands in the FIFO this cycle, so it already counts as occupancy.
  assign push      = inflight_q;
  assign rvalid    = (fcnt_q != 2'd0);
  assign pop       = rvalid && bus.rready_i;
  assign occ       = {1'b0, inflight_q} + fcnt_q;
  assign occ_after = occ - {1'b0, pop};
  assign read_ok   = (occ_after < 2'd2);

  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rvalid ? fifo_q[rd_ptr_q] : '0;
  assign bus.gnt_o    = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fcnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_q_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    inflight_d  = 1'b0;
    gnt         = 1'b0;
    init_done_o = 1'b0;
    sram_ren_o  = 1'b0;
    sram_wen_o  = 1'b0;
    sram_adr_o  = '0;
    sram_din_o  = '0;
    sram_wbeb_o = '1;
    case (state_q)
      ST_RESET: begin
        init_done_o = !INIT_ON_RESET;
        state_d     = INIT_ON_RESET ? ST_INIT : ST_IDLE;
      end
      ST_INIT: begin
        sram_wen_o  = 1'b1;
        sram_adr_o  = cnt_q;
        sram_wbeb_o = '0;
        cnt_d       = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        init_done_o = 1'b1;
        gnt         = bus.we_i ? 1'b1 : read_ok;
        if (bus.req_i && gnt) begin
          sram_adr_o = bus.addr_i;
          if (bus.we_i) begin
            sram_wen_o  = 1'b1;
            sram_din_o  = bus.wdata_i;
            sram_wbeb_o = ~bus.wmask_i;
          end else begin
            sram_ren_o = 1'b1;
            inflight_d = 1'b1;
          end
        end
        if (init_req_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (occ == 2'd0) begin
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_sram_512x80_ctrl.sv
// tb/tb_sram_512x80_ctrl.sv - randomized self-checking bench for sram_512x80_ctrl
module tb_sram_512x80_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_512x80_ctrl_if bus ();

  logic        init_req, init_done;
  logic        sram_ren, sram_wen;
  logic [8:0]  sram_adr;
  logic [79:0] sram_din, sram_wbeb, sram_q;
  logic [2:0]  sram_mc;
  logic        sram_mcen, sram_clkbyp, sram_wpulseen, sram_fwen;
  logic [1:0]  sram_wa, sram_wpulse;

  sram_512x80_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave),
    .init_req_i(init_req), .init_done_o(init_done),
    .sram_ren_o(sram_ren), .sram_wen_o(sram_wen), .sram_adr_o(sram_adr),
    .sram_din_o(sram_din), .sram_wbeb_o(sram_wbeb), .sram_mc_o(sram_mc),
    .sram_mcen_o(sram_mcen), .sram_clkbyp_o(sram_clkbyp), .sram_wa_o(sram_wa),
    .sram_wpulse_o(sram_wpulse), .sram_wpulseen_o(sram_wpulseen),
    .sram_fwen_o(sram_fwen), .sram_q_i(sram_q)
  );

  // Hard macro: registered read, per-bit active-low write enable.
  logic [79:0] macro_mem [512];
  logic [79:0] q_r;
  assign sram_q = q_r;
  always @(posedge clk) begin
    if (sram_ren) q_r <= macro_mem[sram_adr];
    if (sram_wen) macro_mem[sram_adr] <= (macro_mem[sram_adr] & sram_wbeb) | (sram_din & ~sram_wbeb);
  end

  typedef struct { logic [79:0] d; int c; } rsp_t;
  rsp_t        exp_q [$];
  logic [79:0] shadow [512];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic s_wen, s_ren, s_done;
  logic [79:0] s_wbeb;

  function automatic logic [79:0] rand80();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[79:0];
  endfunction

  task automatic step(input logic req, input logic we, input logic [8:0] addr,
                      input logic [79:0] wd, input logic [79:0] wm, input logic rr,
                      input bit chk, output logic g, output logic rv);
    logic exp_g, exp_rv, pop;
    bus.req_i = req; bus.we_i = we; bus.addr_i = addr;
    bus.wdata_i = wd; bus.wmask_i = wm; bus.rready_i = rr;
    @(negedge clk);
    g = bus.gnt_o; rv = bus.rvalid_o;
    s_wen = sram_wen; s_ren = sram_ren; s_done = init_done; s_wbeb = sram_wbeb;
    exp_rv = (exp_q.size() > 0) && (cyc >= exp_q[0].c + 2);
    checks++;
    if (rv !== exp_rv) begin errors++; $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rv, exp_rv); end
    pop = rv && rr;
    exp_g = we ? 1'b1 : ((exp_q.size() - int'(pop)) < 2);
    if (chk) begin
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, g, exp_g); end
      checks++;
      if (req && g && we) begin
        if (sram_wen !== 1'b1 || sram_ren !== 1'b0 || sram_adr !== addr || sram_din !== wd || sram_wbeb !== ~wm) begin
          errors++; $display("FAIL wr_cycle cyc=%0d wen=%b ren=%b adr=%h wbeb=%h exp adr=%h wbeb=%h", cyc, sram_wen, sram_ren, sram_adr, sram_wbeb, addr, ~wm);
        end
      end else if (req && g) begin
        if (sram_ren !== 1'b1 || sram_wen !== 1'b0 || sram_adr !== addr || sram_din !== 80'h0 || sram_wbeb !== '1) begin
          errors++; $display("FAIL rd_cycle cyc=%0d ren=%b wen=%b adr=%h exp adr=%h", cyc, sram_ren, sram_wen, sram_adr, addr);
        end
      end else if (sram_ren !== 1'b0 || sram_wen !== 1'b0 || sram_adr !== 9'h0 || sram_wbeb !== '1) begin
        errors++; $display("FAIL idle_cycle cyc=%0d ren=%b wen=%b adr=%h", cyc, sram_ren, sram_wen, sram_adr);
      end
    end
    if (pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rdata_extra cyc=%0d got=%h exp=none", cyc, bus.rdata_o);
      end else begin
        if (bus.rdata_o !== exp_q[0].d) begin
          errors++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata_o, exp_q[0].d);
        end
        void'(exp_q.pop_front());
      end
    end
    if (req && g) begin
      if (we) shadow[addr] = (shadow[addr] & ~wm) | (wd & wm);
      else    exp_q.push_back('{shadow[addr], cyc});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain_q();
    logic g, rv;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(0, 0, 9'h0, 80'h0, 80'h0, 1, 1, g, rv);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain left=%0d exp=0", exp_q.size()); end
  endtask

  // Assert reset, release it and follow the zero sweep up to cycle stop_at (or to completion).
  task automatic run_init(input int stop_at);
    bus.req_i = 0; bus.we_i = 0; bus.rready_i = 0; init_req = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    for (int k = 0; k <= 513; k++) begin
      @(negedge clk);
      checks++;
      if (k == 0) begin
        if (init_done !== 1'b0 || sram_wen !== 1'b0 || bus.gnt_o !== 1'b0) begin
          errors++; $display("FAIL init_start done=%b wen=%b gnt=%b", init_done, sram_wen, bus.gnt_o);
        end
      end else if (k <= 512) begin
        if (sram_wen !== 1'b1 || sram_ren !== 1'b0 || sram_adr !== 9'(k - 1) || sram_wbeb !== 80'h0 ||
            sram_din !== 80'h0 || bus.gnt_o !== 1'b0 || init_done !== 1'b0) begin
          errors++; $display("FAIL init_sweep k=%0d wen=%b adr=%h exp=%h wbeb=%h gnt=%b done=%b", k, sram_wen, sram_adr, 9'(k - 1), sram_wbeb, bus.gnt_o, init_done);
        end
      end else if (init_done !== 1'b1 || sram_wen !== 1'b0) begin
        errors++; $display("FAIL init_done k=%0d done=%b wen=%b exp done=1", k, init_done, sram_wen);
      end
      if (k == stop_at) return;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 512; i++) shadow[i] = 80'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.gnt_o !== 0 || bus.rvalid_o !== 0 || bus.rdata_o !== 80'h0 || init_done !== 0 ||
        sram_ren !== 0 || sram_wen !== 0 || sram_adr !== 9'h0 || sram_din !== 80'h0 || sram_wbeb !== '1) begin
      errors++; $display("FAIL reset_state gnt=%b rvalid=%b done=%b ren=%b wen=%b wbeb=%h", bus.gnt_o, bus.rvalid_o, init_done, sram_ren, sram_wen, sram_wbeb);
    end
    checks++;
    if (sram_mc !== 3'b000 || sram_mcen !== 0 || sram_clkbyp !== 0 || sram_wa !== 2'b00 ||
        sram_wpulse !== 2'b00 || sram_wpulseen !== 0 || sram_fwen !== 0) begin
      errors++; $display("FAIL tieoffs mc=%b mcen=%b wa=%b wpulse=%b exp all 0", sram_mc, sram_mcen, sram_wa, sram_wpulse);
    end
    run_init(-1);
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic g, rv;
    logic [79:0] d;
    d = 80'h1234_5678_9ABC_DEF0_1357;
    step(1, 1, 9'h1A5, d, '1, 1, 1, g, rv);
    step(1, 0, 9'h1A5, 80'h0, 80'h0, 1, 1, g, rv);
    step(0, 0, 9'h0, 80'h0, 80'h0, 1, 1, g, rv);
    step(0, 0, 9'h0, 80'h0, 80'h0, 1, 1, g, rv);
    checks++;
    if (rv !== 1'b1) begin errors++; $display("FAIL rd_latency rvalid=%b exp=1 at +2", rv); end
  endtask

  task automatic test_partial();
    logic g, rv;
    step(1, 1, 9'h7, rand80(), 80'hFF, 1, 1, g, rv);
    checks++;
    if (s_wbeb !== ~80'hFF) begin errors++; $display("FAIL partial_wbeb got=%h exp=%h", s_wbeb, ~80'hFF); end
    step(1, 0, 9'h7, 80'h0, 80'h0, 1, 1, g, rv);
    drain_q();
  endtask

  task automatic test_fifo_full();
    logic g0, g1, g2, rv;
    bit done;
    for (int a = 0; a < 4; a++) step(1, 1, 9'(a), rand80(), '1, 0, 1, g0, rv);
    step(1, 0, 9'h0, 80'h0, 80'h0, 0, 1, g0, rv);
    step(1, 0, 9'h1, 80'h0, 80'h0, 0, 1, g1, rv);
    step(1, 0, 9'h2, 80'h0, 80'h0, 0, 1, g2, rv);
    checks++;
    if (g0 !== 1 || g1 !== 1 || g2 !== 0) begin errors++; $display("FAIL fifo_full gnts=%b%b%b exp=110", g0, g1, g2); end
    for (int a = 2; a < 4; a++) begin
      done = 0;
      for (int t = 0; t < 10 && !done; t++) begin
        step(1, 0, 9'(a), 80'h0, 80'h0, 1, 1, g0, rv);
        done = g0;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL fifo_regrant addr=%0d got=0 exp=1", a); end
    end
    drain_q();
  endtask

  task automatic test_back_to_back();
    logic g, rv;
    int grants = 0, beats = 0;
    for (int i = 0; i < 11; i++) begin
      step(i < 8, 0, 9'($urandom_range(0, 511)), 80'h0, 80'h0, 1, 1, g, rv);
      if (i < 8 && g) grants++;
      if (i >= 2 && i < 10 && rv) beats++;
    end
    checks++;
    if (grants != 8 || beats != 8) begin errors++; $display("FAIL back_to_back grants=%0d beats=%0d exp=8/8", grants, beats); end
    drain_q();
  endtask

  task automatic test_random();
    logic g, rv;
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 9'($urandom_range(0, 15)), rand80(), rand80(), 1'($urandom), 1, g, rv);
    drain_q();
  endtask

  task automatic test_init_req();
    logic g, rv;
    int wcnt = 0;
    bit done = 0;
    step(1, 1, 9'h5, rand80(), '1, 0, 1, g, rv);
    step(1, 0, 9'h5, 80'h0, 80'h0, 0, 1, g, rv);
    step(0, 0, 9'h0, 80'h0, 80'h0, 0, 1, g, rv);
    init_req = 1;
    step(0, 0, 9'h0, 80'h0, 80'h0, 0, 1, g, rv);
    init_req = 0;
    step(1, 0, 9'h3, 80'h0, 80'h0, 0, 0, g, rv);
    checks++;
    if (g !== 0 || s_wen !== 0 || s_ren !== 0) begin errors++; $display("FAIL drain_hold gnt=%b wen=%b ren=%b exp=000", g, s_wen, s_ren); end
    step(0, 0, 9'h0, 80'h0, 80'h0, 1, 0, g, rv);
    for (int t = 0; t < 600 && !done; t++) begin
      step(0, 0, 9'h0, 80'h0, 80'h0, 1, 0, g, rv);
      if (s_wen && s_wbeb == 80'h0) wcnt++;
      done = s_done;
    end
    checks++;
    if (!done || wcnt != 512) begin errors++; $display("FAIL reinit done=%b writes=%0d exp=1/512", done, wcnt); end
    for (int i = 0; i < 512; i++) shadow[i] = 80'h0;
    step(1, 0, 9'h5, 80'h0, 80'h0, 1, 1, g, rv);
    drain_q();
  endtask

  task automatic test_reset_mid_init();
    run_init(301);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sram_wen !== 0 || sram_ren !== 0 || init_done !== 0) begin
      errors++; $display("FAIL mid_reset wen=%b ren=%b done=%b exp=000", sram_wen, sram_ren, init_done);
    end
    run_init(-1);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin macro_mem[i] = rand80(); shadow[i] = 80'h0; end
    init_req = 0;
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = '0; bus.wdata_i = '0; bus.wmask_i = '0; bus.rready_i = 0;
    test_reset();
    test_write_read();
    test_partial();
    test_fifo_full();
    test_back_to_back();
    test_random();
    test_init_req();
    test_reset_mid_init();
    test_write_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout time=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
